// File: rtl/alu_mdu.sv
// Registered execute-stage ALU with valid/ready handshake and an iterative multiply/divide unit.
// Single-cycle ops return one cycle after acceptance; MULT/DIV take WIDTH+1 cycles.
module alu_mdu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [4:0]       i_alu_control,
    input  logic [WIDTH-1:0] i_data_A,
    input  logic [WIDTH-1:0] i_data_B,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_result,
    output logic [WIDTH-1:0] o_result_hi,
    output logic             o_zero_flag,
    output logic             o_div_zero
);

    localparam int unsigned SW = $clog2(WIDTH);
    localparam logic [SW:0] COUNT_INIT = (SW+1)'(WIDTH);
    localparam logic [SW:0] COUNT_ONE  = (SW+1)'(1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [4:0] OP_AND  = 5'b00000;
    localparam logic [4:0] OP_OR   = 5'b00001;
    localparam logic [4:0] OP_ADD  = 5'b00010;
    localparam logic [4:0] OP_XOR  = 5'b00011;
    localparam logic [4:0] OP_NOR  = 5'b00100;
    localparam logic [4:0] OP_SLTU = 5'b00101;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SLT  = 5'b00111;
    localparam logic [4:0] OP_SLL  = 5'b01000;
    localparam logic [4:0] OP_SRL  = 5'b01001;
    localparam logic [4:0] OP_SRA  = 5'b01010;
    localparam logic [4:0] OP_ROR  = 5'b01011;
    localparam logic [4:0] OP_ROL  = 5'b01100;
    localparam logic [4:0] OP_MFHI = 5'b10100;
    localparam logic [4:0] OP_MFLO = 5'b10101;

    logic [1:0]         state_q;
    logic [SW:0]        count_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic [WIDTH-1:0]   acc_hi_q, acc_lo_q, mag_b_q, a_q;
    logic               is_div_q, neg_lo_q, neg_hi_q, div_zero_q;

    logic               accept, is_mdu, op_signed, op_div, a_neg, b_neg;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [SW-1:0]      shamt;
    logic [2*WIDTH-1:0] rot_r, rot_l;
    logic [WIDTH-1:0]   alu_res;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [WIDTH-1:0]   iter_hi, iter_lo;
    logic [2*WIDTH-1:0] prod, prod_s;
    logic [WIDTH-1:0]   fin_hi, fin_lo;

    assign o_ready   = (state_q != BUSY);
    assign accept    = i_valid && o_ready;
    assign is_mdu    = (i_alu_control[4:2] == 3'b100);
    assign op_signed = i_alu_control[0];
    assign op_div    = i_alu_control[1];
    assign a_neg     = op_signed & i_data_A[WIDTH-1];
    assign b_neg     = op_signed & i_data_B[WIDTH-1];
    assign mag_a     = a_neg ? -i_data_A : i_data_A;
    assign mag_b     = b_neg ? -i_data_B : i_data_B;

    always_comb begin
        shamt   = i_data_A[SW-1:0];
        rot_r   = {i_data_B, i_data_B} >> shamt;
        rot_l   = {i_data_B, i_data_B} << shamt;
        alu_res = '0;
        case (i_alu_control)
            OP_ADD:  alu_res = i_data_A + i_data_B;
            OP_SUB:  alu_res = i_data_A - i_data_B;
            OP_AND:  alu_res = i_data_A & i_data_B;
            OP_OR:   alu_res = i_data_A | i_data_B;
            OP_XOR:  alu_res = i_data_A ^ i_data_B;
            OP_NOR:  alu_res = ~(i_data_A | i_data_B);
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(i_data_A) < $signed(i_data_B)};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, i_data_A < i_data_B};
            OP_SLL:  alu_res = i_data_B << shamt;
            OP_SRL:  alu_res = i_data_B >> shamt;
            OP_SRA:  alu_res = $signed(i_data_B) >>> shamt;
            OP_ROR:  alu_res = rot_r[WIDTH-1:0];
            OP_ROL:  alu_res = rot_l[2*WIDTH-1:WIDTH];
            // While in DONE the fresh HI/LO still sit in the output registers; forward them.
            OP_MFHI: alu_res = (state_q == DONE) ? o_result_hi : hi_q;
            OP_MFLO: alu_res = (state_q == DONE) ? o_result : lo_q;
            default: alu_res = '0;
        endcase
    end

    // One shift-add or restoring-divide step on the magnitude accumulator.
    always_comb begin
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mag_b_q} : '0);
        div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, mag_b_q};
        if (is_div_q) begin
            if (!div_diff[WIDTH]) begin
                iter_hi = div_diff[WIDTH-1:0];
                iter_lo = {acc_lo_q[WIDTH-2:0], 1'b1};
            end else begin
                iter_hi = div_shift[WIDTH-1:0];
                iter_lo = {acc_lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            iter_hi = mul_sum[WIDTH:1];
            iter_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        prod   = {iter_hi, iter_lo};
        prod_s = neg_lo_q ? -prod : prod;
        if (is_div_q) begin
            if (div_zero_q) begin
                fin_lo = '1;
                fin_hi = a_q;
            end else begin
                fin_lo = neg_lo_q ? -iter_lo : iter_lo;
                fin_hi = neg_hi_q ? -iter_hi : iter_hi;
            end
        end else begin
            fin_lo = prod_s[WIDTH-1:0];
            fin_hi = prod_s[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            acc_hi_q    <= '0;
            acc_lo_q    <= '0;
            mag_b_q     <= '0;
            a_q         <= '0;
            is_div_q    <= 1'b0;
            neg_lo_q    <= 1'b0;
            neg_hi_q    <= 1'b0;
            div_zero_q  <= 1'b0;
            o_valid     <= 1'b0;
            o_result    <= '0;
            o_result_hi <= '0;
            o_zero_flag <= 1'b1;
            o_div_zero  <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            case (state_q)
                BUSY: begin
                    acc_hi_q <= iter_hi;
                    acc_lo_q <= iter_lo;
                    count_q  <= count_q - COUNT_ONE;
                    if (count_q == COUNT_ONE) begin
                        state_q     <= DONE;
                        o_valid     <= 1'b1;
                        o_result    <= fin_lo;
                        o_result_hi <= fin_hi;
                        o_zero_flag <= (fin_lo == '0);
                        o_div_zero  <= div_zero_q;
                    end
                end
                default: begin
                    if (state_q == DONE) begin
                        hi_q    <= o_result_hi;
                        lo_q    <= o_result;
                        state_q <= IDLE;
                    end
                    if (accept) begin
                        if (is_mdu) begin
                            state_q    <= BUSY;
                            count_q    <= COUNT_INIT;
                            is_div_q   <= op_div;
                            neg_lo_q   <= a_neg ^ b_neg;
                            neg_hi_q   <= a_neg;
                            div_zero_q <= op_div && (i_data_B == '0);
                            a_q        <= i_data_A;
                            acc_hi_q   <= '0;
                            // Multiply: multiplier shifts out of LO. Divide: dividend does.
                            acc_lo_q   <= op_div ? mag_a : mag_b;
                            mag_b_q    <= op_div ? mag_b : mag_a;
                        end else begin
                            o_valid     <= 1'b1;
                            o_result    <= alu_res;
                            o_result_hi <= '0;
                            o_zero_flag <= (alu_res == '0);
                            o_div_zero  <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu: directed scenarios plus random ops against an
// arithmetic reference model.
module tb_alu_mdu;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          i_reset;
    logic          i_valid;
    logic          o_ready;
    logic [4:0]    i_alu_control;
    logic [W-1:0]  i_data_A, i_data_B;
    logic          o_valid;
    logic [W-1:0]  o_result, o_result_hi;
    logic          o_zero_flag, o_div_zero;

    int total = 0;
    int bad   = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    logic [4:0] single_ops [16] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101,
                                    5'b00110, 5'b00111, 5'b01000, 5'b01001, 5'b01010, 5'b01011,
                                    5'b01100, 5'b10100, 5'b10101, 5'b01110};

    always #5 clk = ~clk;

    alu_mdu #(.WIDTH(W)) dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_alu_control(i_alu_control),
        .i_data_A     (i_data_A),
        .i_data_B     (i_data_B),
        .o_valid      (o_valid),
        .o_result     (o_result),
        .o_result_hi  (o_result_hi),
        .o_zero_flag  (o_zero_flag),
        .o_div_zero   (o_div_zero)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] lo, output logic [31:0] hi,
                                  output logic dz, output bit mdu);
        longint      sa, sb, p, q, r;
        logic [63:0] up;
        lo = '0; hi = '0; dz = 1'b0; mdu = 1'b0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            5'b00010: lo = a + b;
            5'b00110: lo = a - b;
            5'b00000: lo = a & b;
            5'b00001: lo = a | b;
            5'b00011: lo = a ^ b;
            5'b00100: lo = ~(a | b);
            5'b00111: lo = (sa < sb) ? 32'd1 : 32'd0;
            5'b00101: lo = (a < b) ? 32'd1 : 32'd0;
            5'b01000: lo = b << a[4:0];
            5'b01001: lo = b >> a[4:0];
            5'b01010: lo = 32'($signed(b) >>> a[4:0]);
            5'b01011: begin
                lo = b;
                for (int i = 0; i < int'(a[4:0]); i++) lo = {lo[0], lo[31:1]};
            end
            5'b01100: begin
                lo = b;
                for (int i = 0; i < int'(a[4:0]); i++) lo = {lo[30:0], lo[31]};
            end
            5'b10100: lo = m_hi;
            5'b10101: lo = m_lo;
            5'b10000: begin
                mdu = 1'b1;
                up = {32'b0, a} * {32'b0, b};
                {hi, lo} = up;
            end
            5'b10001: begin
                mdu = 1'b1;
                p = sa * sb;
                {hi, lo} = p;
            end
            5'b10010, 5'b10011: begin
                mdu = 1'b1;
                if (b == '0) begin
                    lo = '1; hi = a; dz = 1'b1;
                end else if (op[0]) begin
                    q = sa / sb;
                    r = sa % sb;
                    lo = q[31:0];
                    hi = r[31:0];
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
            default: lo = '0;
        endcase
    endfunction

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    task automatic check_res(input string tag, input logic [31:0] lo, input logic [31:0] hi,
                             input logic dz);
        chk({tag, "_valid"}, 64'(o_valid), 64'd1);
        chk({tag, "_lo"}, 64'(o_result), 64'(lo));
        chk({tag, "_hi"}, 64'(o_result_hi), 64'(hi));
        chk({tag, "_zero"}, 64'(o_zero_flag), 64'(lo == '0));
        chk({tag, "_dz"}, 64'(o_div_zero), 64'(dz));
    endtask

    task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        i_valid       = 1'b1;
        i_alu_control = op;
        i_data_A      = a;
        i_data_B      = b;
    endtask

    // Issue one op from idle and check its result at the required latency.
    task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
        logic [31:0] elo, ehi;
        logic        edz;
        bit          emdu;
        model(op, a, b, elo, ehi, edz, emdu);
        @(negedge clk);
        chk({tag, "_ready_in"}, 64'(o_ready), 64'd1);
        drive(op, a, b);
        @(posedge clk);
        #1 i_valid = 1'b0;
        if (emdu) begin
            for (int c = 1; c <= W; c++) begin
                @(negedge clk);
                chk({tag, "_busy_ready"}, 64'(o_ready), 64'd0);
                chk({tag, "_busy_valid"}, 64'(o_valid), 64'd0);
            end
        end
        @(negedge clk);
        check_res(tag, elo, ehi, edz);
        if (emdu) begin
            m_hi = ehi;
            m_lo = elo;
        end
    endtask

    // Back-to-back single-cycle ops: one result per cycle.
    task automatic stream(input int n);
        logic [31:0] elo, ehi, plo, a, b;
        logic        edz;
        bit          emdu;
        logic [4:0]  op;
        plo = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i > 0) check_res("stream", plo, 32'h0, 1'b0);
            op = single_ops[$urandom_range(0, 15)];
            a  = rnd_word();
            b  = rnd_word();
            model(op, a, b, elo, ehi, edz, emdu);
            plo = elo;
            drive(op, a, b);
        end
        @(posedge clk);
        #1 i_valid = 1'b0;
        @(negedge clk);
        check_res("stream", plo, 32'h0, 1'b0);
    endtask

    initial begin
        logic [31:0] elo, ehi;
        logic        edz;
        bit          emdu;
        logic [4:0]  op;

        i_reset = 1'b1;
        i_valid = 1'b0;
        i_alu_control = '0;
        i_data_A = '0;
        i_data_B = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        i_reset = 1'b0;
        chk("rst_ready", 64'(o_ready), 64'd1);
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_lo", 64'(o_result), 64'd0);
        chk("rst_hi", 64'(o_result_hi), 64'd0);
        chk("rst_zero", 64'(o_zero_flag), 64'd1);
        chk("rst_dz", 64'(o_div_zero), 64'd0);

        // ADD wrap then back-to-back SUB.
        @(negedge clk);
        drive(5'b00010, 32'hFFFF_FFFF, 32'd1);
        @(posedge clk);
        #1 drive(5'b00110, 32'd5, 32'd7);
        @(negedge clk);
        check_res("add_wrap", 32'h0, 32'h0, 1'b0);
        @(posedge clk);
        #1 i_valid = 1'b0;
        @(negedge clk);
        check_res("sub_b2b", 32'hFFFF_FFFE, 32'h0, 1'b0);
        @(negedge clk);
        chk("idle_valid", 64'(o_valid), 64'd0);

        do_op(5'b00111, 32'hFFFF_FFFF, 32'd1, "slt");
        do_op(5'b00101, 32'hFFFF_FFFF, 32'd1, "sltu");
        do_op(5'b01010, 32'd4, 32'h8000_0000, "sra");
        do_op(5'b01100, 32'd1, 32'h8000_0001, "rol");
        do_op(5'b01011, 32'd0, 32'h1234_5678, "ror0");
        do_op(5'b11011, 32'd9, 32'd9, "undef");
        do_op(5'b10001, -32'sd3, 32'd7, "mult");
        do_op(5'b10100, 32'd0, 32'd0, "mfhi");
        do_op(5'b10011, -32'sd7, 32'd2, "div");
        do_op(5'b10010, 32'd100, 32'd0, "divu_z");
        do_op(5'b10011, 32'h8000_0000, 32'hFFFF_FFFF, "div_minneg1");
        do_op(5'b10011, -32'sd5, 32'd0, "div_z");
        do_op(5'b10000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        do_op(5'b10101, 32'd0, 32'd0, "mflo");

        // ADD held valid through a MULT: accepted only in DONE.
        model(5'b10001, 32'd12345, -32'sd678, elo, ehi, edz, emdu);
        @(negedge clk);
        drive(5'b10001, 32'd12345, -32'sd678);
        @(posedge clk);
        #1 drive(5'b00010, 32'd40, 32'd2);
        for (int c = 1; c <= W; c++) begin
            @(negedge clk);
            chk("hold_ready", 64'(o_ready), 64'd0);
            chk("hold_valid", 64'(o_valid), 64'd0);
        end
        @(negedge clk);
        check_res("hold_mult", elo, ehi, edz);
        chk("hold_done_ready", 64'(o_ready), 64'd1);
        m_hi = ehi;
        m_lo = elo;
        @(posedge clk);
        #1 i_valid = 1'b0;
        @(negedge clk);
        check_res("hold_add", 32'd42, 32'h0, 1'b0);
        @(negedge clk);
        chk("hold_once", 64'(o_valid), 64'd0);
        do_op(5'b10100, 32'd0, 32'd0, "hold_mfhi");

        // Reset in the middle of a MULTU aborts it.
        @(negedge clk);
        drive(5'b10000, 32'd123456, 32'd789);
        @(posedge clk);
        #1 i_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        i_reset = 1'b1;
        @(posedge clk);
        #1 i_reset = 1'b0;
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        chk("abort_ready", 64'(o_ready), 64'd1);
        chk("abort_valid", 64'(o_valid), 64'd0);
        chk("abort_lo", 64'(o_result), 64'd0);
        chk("abort_zero", 64'(o_zero_flag), 64'd1);
        do_op(5'b10101, 32'd0, 32'd0, "abort_mflo");
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            chk("abort_quiet", 64'(o_valid), 64'd0);
        end

        // Random ops from idle, then a random back-to-back stream.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) op = 5'(5'b10000 + $urandom_range(0, 3));
            else if ($urandom_range(0, 9) == 0) op = 5'b11101;
            else op = single_ops[$urandom_range(0, 15)];
            do_op(op, rnd_word(), rnd_word(), "rand");
        end
        stream(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
